// File: rtl/sr_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : sr_cmd_sequencer_if
// Description : Request/command bundle between a request source and the
//               SR command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface sr_cmd_sequencer_if;
    logic       set_in;
    logic       rst_in;
    logic [1:0] sr;
    logic       busy;
    logic       shadow_q;
    logic       conflict;
    logic [7:0] conflict_cnt;

    modport master (
        output set_in,
        output rst_in,
        input  sr,
        input  busy,
        input  shadow_q,
        input  conflict,
        input  conflict_cnt
    );

    modport slave (
        input  set_in,
        input  rst_in,
        output sr,
        output busy,
        output shadow_q,
        output conflict,
        output conflict_cnt
    );
endinterface
`default_nettype wire

// File: rtl/sr_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sr_cmd_sequencer
// Description : Synchronises, debounces and arbitrates raw set/reset requests
//               into clean sr[1:0] command pulses for a clocked SR flip-flop.
//               Optional macro SR_CONFLICT_CNT_EN builds a saturating
//               conflict counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_cmd_sequencer #(
    parameter int DEB_CYCLES = 4,
    parameter int PULSE_CYC  = 1,
    parameter int HOLDOFF    = 2,
    parameter int PRIO_SET   = 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    sr_cmd_sequencer_if.slave bus
);

    localparam int c_DW = $clog2(DEB_CYCLES + 1);
    localparam int c_PW = $clog2(PULSE_CYC + 1);
    localparam int c_HW = $clog2(HOLDOFF + 2);

    localparam logic [c_DW-1:0] c_DEB_MAX    = c_DW'(DEB_CYCLES);
    localparam logic [c_DW-1:0] c_DEB_THR    = c_DW'(DEB_CYCLES - 1);
    localparam logic [c_PW-1:0] c_PULSE_LAST = c_PW'(PULSE_CYC - 1);
    localparam logic [c_HW-1:0] c_HOLD_LAST  = c_HW'(HOLDOFF - 1);
    localparam logic            c_PRIO_SET   = (PRIO_SET != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Bit 1 is the set path, bit 0 the reset path, matching sr[1:0].
    logic [1:0] w_raw;
    logic [1:0] w_pend;
    logic       w_idle;

    assign w_raw = {bus.set_in, bus.rst_in};

    for (genvar i = 0; i < 2; i++) begin : g_path
        logic            r_sync1;
        logic            r_sync2;
        logic            r_deb;
        logic            r_pend;
        logic [c_DW-1:0] r_cnt;
        logic            w_deb_nxt;

        // Level rises on the DEB_CYCLES-th consecutive high sample.
        assign w_deb_nxt = r_sync2 && (r_cnt >= c_DEB_THR);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_cnt   <= '0;
                r_deb   <= 1'b0;
                r_pend  <= 1'b0;
            end else begin
                r_sync1 <= w_raw[i];
                r_sync2 <= r_sync1;
                if (!r_sync2) begin
                    r_cnt <= '0;
                end else if (r_cnt != c_DEB_MAX) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                r_deb  <= w_deb_nxt;
                // The FSM consumes every pending request it sees while idle.
                r_pend <= (r_pend && !w_idle) || (w_deb_nxt && !r_deb);
            end
        end

        assign w_pend[i] = r_pend;
    end

    state_t          r_state;
    logic [1:0]      r_sr;
    logic            r_busy;
    logic            r_shadow;
    logic            r_conflict;
    logic [c_PW-1:0] r_pcnt;
    logic [c_HW-1:0] r_hcnt;
    logic            w_both;
    logic            w_win_set;
    logic            w_win_rst;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_both    = &w_pend;
    assign w_win_set = w_pend[1] && (!w_pend[0] || c_PRIO_SET);
    assign w_win_rst = w_pend[0] && (!w_pend[1] || !c_PRIO_SET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_sr       <= 2'b00;
            r_busy     <= 1'b0;
            r_shadow   <= 1'b0;
            r_conflict <= 1'b0;
            r_pcnt     <= '0;
            r_hcnt     <= '0;
        end else begin
            r_conflict <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_conflict <= w_both;
                    r_pcnt     <= '0;
                    // Requests matching the shadow state are dropped silently.
                    if (w_win_set && !r_shadow) begin
                        r_sr     <= 2'b10;
                        r_shadow <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= ST_PULSE;
                    end else if (w_win_rst && r_shadow) begin
                        r_sr     <= 2'b01;
                        r_shadow <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (r_pcnt == c_PULSE_LAST) begin
                        r_sr   <= 2'b00;
                        r_hcnt <= '0;
                        if (HOLDOFF > 0) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_pcnt <= r_pcnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (r_hcnt == c_HOLD_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_sr    <= 2'b00;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SR_CONFLICT_CNT_EN
    logic [7:0] r_conflict_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict_cnt <= 8'd0;
        end else if (w_idle && w_both && (r_conflict_cnt != 8'hFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 8'd1;
        end
    end

    assign bus.conflict_cnt = r_conflict_cnt;
`else
    assign bus.conflict_cnt = 8'd0;
`endif

    assign bus.sr       = r_sr;
    assign bus.busy     = r_busy;
    assign bus.shadow_q = r_shadow;
    assign bus.conflict = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_sr_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_cmd_sequencer
// Description : Directed self-checking bench for sr_cmd_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_cmd_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

`ifdef SR_CONFLICT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    sr_cmd_sequencer_if bus0();
    sr_cmd_sequencer_if bus1();
    sr_cmd_sequencer_if bus2();

    sr_cmd_sequencer #(.DEB_CYCLES(4), .PULSE_CYC(1), .HOLDOFF(2), .PRIO_SET(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    sr_cmd_sequencer #(.DEB_CYCLES(4), .PULSE_CYC(1), .HOLDOFF(2), .PRIO_SET(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );
    sr_cmd_sequencer #(.DEB_CYCLES(4), .PULSE_CYC(3), .HOLDOFF(2), .PRIO_SET(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    // Illegal-code and command-spacing scoreboard for all three instances.
    initial begin
        logic [1:0] cur  [3];
        logic [1:0] prev [3];
        int         last [3];
        bit         have [3];
        int         gap;
        for (int i = 0; i < 3; i++) begin
            prev[i] = 2'b00;
            last[i] = 0;
            have[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            cur[0] = bus0.sr;
            cur[1] = bus1.sr;
            cur[2] = bus2.sr;
            for (int i = 0; i < 3; i++) begin
                gap = (i == 2) ? 5 : 3;
                if (!rst_n) begin
                    have[i] = 1'b0;
                    prev[i] = 2'b00;
                end else begin
                    checks++;
                    if (cur[i] === 2'b11) begin
                        errors++;
                        $display("FAIL sb_illegal dut%0d sr=%b required not 11", i, cur[i]);
                    end
                    if (cur[i] != 2'b00 && prev[i] == 2'b00) begin
                        if (have[i]) begin
                            checks++;
                            if (cyc - last[i] < gap) begin
                                errors++;
                                $display("FAIL sb_spacing dut%0d gap=%0d required >=%0d", i, cyc - last[i], gap);
                            end
                        end
                        have[i] = 1'b1;
                        last[i] = cyc;
                    end
                    prev[i] = cur[i];
                end
            end
        end
    end

    task automatic clear_inputs();
        bus0.set_in = 1'b0; bus0.rst_in = 1'b0;
        bus1.set_in = 1'b0; bus1.rst_in = 1'b0;
        bus2.set_in = 1'b0; bus2.rst_in = 1'b0;
    endtask

    // Leaves the bench at a falling edge with reset released; next rising edge is cycle 0.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus0.set_in = 1'b1; bus0.rst_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus0.sr !== 2'b00) begin errors++; $display("FAIL reset_sr sr=%b required 00", bus0.sr); end
        checks++;
        if (bus0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy busy=%b required 0", bus0.busy); end
        checks++;
        if (bus0.shadow_q !== 1'b0) begin errors++; $display("FAIL reset_shadow shadow_q=%b required 0", bus0.shadow_q); end
        checks++;
        if (bus0.conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict conflict=%b required 0", bus0.conflict); end
        checks++;
        if (bus0.conflict_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt conflict_cnt=%0d required 0", bus0.conflict_cnt); end
        clear_inputs();
    endtask

    task automatic test_latency();
        logic [1:0] exp_sr;
        logic       exp_busy;
        logic       exp_sh;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            bus0.set_in = 1'b1;
            @(negedge clk);
            exp_sr   = (k == 6) ? 2'b10 : 2'b00;
            exp_busy = (k >= 6 && k <= 8);
            exp_sh   = (k >= 6);
            checks++;
            if (bus0.sr !== exp_sr) begin errors++; $display("FAIL latency_sr k=%0d sr=%b required %b", k, bus0.sr, exp_sr); end
            checks++;
            if (bus0.busy !== exp_busy) begin errors++; $display("FAIL latency_busy k=%0d busy=%b required %b", k, bus0.busy, exp_busy); end
            checks++;
            if (bus0.shadow_q !== exp_sh) begin errors++; $display("FAIL latency_shadow k=%0d shadow_q=%b required %b", k, bus0.shadow_q, exp_sh); end
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int k = 0; k < 40; k++) begin
            bus0.set_in = (k < 20) ? (((k / 2) % 2) == 0) : 1'b0;
            @(negedge clk);
            checks++;
            if (bus0.sr !== 2'b00) begin errors++; $display("FAIL bounce_sr k=%0d sr=%b required 00", k, bus0.sr); end
            checks++;
            if (bus0.shadow_q !== 1'b0) begin errors++; $display("FAIL bounce_shadow k=%0d shadow_q=%b required 0", k, bus0.shadow_q); end
        end
    endtask

    task automatic test_conflict();
        logic [1:0] exp_sr;
        logic [7:0] exp_cnt;
        do_reset();
        for (int k = 0; k < 13; k++) begin
            bus0.set_in = 1'b1; bus0.rst_in = 1'b1;
            bus1.set_in = 1'b1; bus1.rst_in = 1'b1;
            @(negedge clk);
            exp_sr  = (k == 6) ? 2'b10 : 2'b00;
            exp_cnt = (CNT_EN && k >= 6) ? 8'd1 : 8'd0;
            checks++;
            if (bus0.conflict !== (k == 6)) begin errors++; $display("FAIL conflict_p1 k=%0d conflict=%b required %b", k, bus0.conflict, (k == 6)); end
            checks++;
            if (bus0.sr !== exp_sr) begin errors++; $display("FAIL conflict_sr_p1 k=%0d sr=%b required %b", k, bus0.sr, exp_sr); end
            checks++;
            if (bus0.shadow_q !== (k >= 6)) begin errors++; $display("FAIL conflict_shadow_p1 k=%0d shadow_q=%b required %b", k, bus0.shadow_q, (k >= 6)); end
            checks++;
            if (bus0.conflict_cnt !== exp_cnt) begin errors++; $display("FAIL conflict_cnt_p1 k=%0d cnt=%0d required %0d", k, bus0.conflict_cnt, exp_cnt); end
            checks++;
            if (bus1.conflict !== (k == 6)) begin errors++; $display("FAIL conflict_p0 k=%0d conflict=%b required %b", k, bus1.conflict, (k == 6)); end
            checks++;
            if (bus1.sr !== 2'b00) begin errors++; $display("FAIL conflict_sr_p0 k=%0d sr=%b required 00", k, bus1.sr); end
            checks++;
            if (bus1.shadow_q !== 1'b0) begin errors++; $display("FAIL conflict_shadow_p0 k=%0d shadow_q=%b required 0", k, bus1.shadow_q); end
        end
        clear_inputs();
    endtask

    task automatic test_redundant();
        logic [1:0] exp_sr;
        do_reset();
        for (int k = 0; k < 25; k++) begin
            bus0.set_in = (k < 8 || k >= 12);
            @(negedge clk);
            exp_sr = (k == 6) ? 2'b10 : 2'b00;
            checks++;
            if (bus0.sr !== exp_sr) begin errors++; $display("FAIL redundant_sr k=%0d sr=%b required %b", k, bus0.sr, exp_sr); end
            checks++;
            if (bus0.shadow_q !== (k >= 6)) begin errors++; $display("FAIL redundant_shadow k=%0d shadow_q=%b required %b", k, bus0.shadow_q, (k >= 6)); end
            checks++;
            if (bus0.busy !== (k >= 6 && k <= 8)) begin errors++; $display("FAIL redundant_busy k=%0d busy=%b required %b", k, bus0.busy, (k >= 6 && k <= 8)); end
        end
        clear_inputs();
    endtask

    task automatic test_hold_pending();
        logic [1:0] exp_sr;
        logic       exp_busy;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            bus0.set_in = 1'b1;
            bus0.rst_in = (k >= 3);
            @(negedge clk);
            exp_sr   = (k == 6) ? 2'b10 : ((k == 10) ? 2'b01 : 2'b00);
            exp_busy = (k >= 6 && k <= 8) || (k >= 10 && k <= 12);
            checks++;
            if (bus0.sr !== exp_sr) begin errors++; $display("FAIL hold_sr k=%0d sr=%b required %b", k, bus0.sr, exp_sr); end
            checks++;
            if (bus0.busy !== exp_busy) begin errors++; $display("FAIL hold_busy k=%0d busy=%b required %b", k, bus0.busy, exp_busy); end
            checks++;
            if (bus0.shadow_q !== (k >= 6 && k < 10)) begin errors++; $display("FAIL hold_shadow k=%0d shadow_q=%b required %b", k, bus0.shadow_q, (k >= 6 && k < 10)); end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_pulse();
        logic [1:0] exp_sr;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            bus2.set_in = 1'b1;
            @(negedge clk);
            exp_sr = (k >= 6) ? 2'b10 : 2'b00;
            checks++;
            if (bus2.sr !== exp_sr) begin errors++; $display("FAIL midrst_pre_sr k=%0d sr=%b required %b", k, bus2.sr, exp_sr); end
        end
        bus2.set_in = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus2.sr !== 2'b00) begin errors++; $display("FAIL midrst_sr sr=%b required 00", bus2.sr); end
        checks++;
        if (bus2.shadow_q !== 1'b0) begin errors++; $display("FAIL midrst_shadow shadow_q=%b required 0", bus2.shadow_q); end
        checks++;
        if (bus2.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy busy=%b required 0", bus2.busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (bus2.sr !== 2'b00) begin errors++; $display("FAIL midrst_post_sr k=%0d sr=%b required 00", k, bus2.sr); end
            checks++;
            if (bus2.shadow_q !== 1'b0) begin errors++; $display("FAIL midrst_post_shadow k=%0d shadow_q=%b required 0", k, bus2.shadow_q); end
        end
    endtask

    task automatic test_conflict_count();
        int         seen;
        logic [7:0] exp_cnt;
        seen = 0;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 12; k++) begin
                bus0.set_in = (k < 8);
                bus0.rst_in = (k < 8);
                @(negedge clk);
                if (bus0.conflict === 1'b1) seen++;
            end
            if (n == 99) begin
                exp_cnt = CNT_EN ? 8'd100 : 8'd0;
                checks++;
                if (bus0.conflict_cnt !== exp_cnt) begin errors++; $display("FAIL cnt_mid cnt=%0d required %0d", bus0.conflict_cnt, exp_cnt); end
            end
        end
        exp_cnt = CNT_EN ? 8'd255 : 8'd0;
        checks++;
        if (bus0.conflict_cnt !== exp_cnt) begin errors++; $display("FAIL cnt_sat cnt=%0d required %0d", bus0.conflict_cnt, exp_cnt); end
        checks++;
        if (seen != 300) begin errors++; $display("FAIL cnt_pulses seen=%0d required 300", seen); end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_latency();
        test_bounce();
        test_conflict();
        test_redundant();
        test_hold_pending();
        test_reset_mid_pulse();
        test_conflict_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
